// File: rtl/data_bus_interconnect.sv
// ---------------------------------------------------------------------------
// data_bus_interconnect
//
// Connects the Grande_Risco5 data port to NUM_SLAVES memory-mapped slaves.
// Each access is decoded by base/mask (lowest matching index wins), forwarded
// to one slave through a registered one-hot strobe, and completed when that
// slave responds. Unmapped addresses, simultaneous read+write requests and
// slaves that do not answer within TIMEOUT_CYCLES all complete with an error
// response: DEFAULT_READ on reads, dropped data on writes, and a one-cycle
// bus_error pulse. This guarantees the core never stalls forever.
//
// Optional feature macro: BUS_ERROR_STATUS_EN
//   defined     -> err_count (saturating) and err_address (last error address)
//   not defined -> err_count and err_address are constant 0
//
// Ports
//   clk, reset            clock, synchronous active-high reset
//   data_address          core address
//   data_memory_read      core read request (held until response)
//   data_memory_write     core write request (held until response)
//   write_data            core write data
//   read_data             registered read data to core
//   data_memory_response  one-cycle completion pulse
//   slave_address         latched address shared by all slaves
//   slave_write_data      latched write data shared by all slaves
//   slave_read            one-hot read strobe
//   slave_write           one-hot write strobe
//   slave_read_data       flat NUM_SLAVES*32 vector, slot i = slave i
//   slave_response        per-slave completion
//   bus_error             one-cycle pulse with an error response
//   err_count             saturating error counter
//   err_address           address of the most recent error
// ---------------------------------------------------------------------------
module data_bus_interconnect #(
    parameter int                        NUM_SLAVES     = 4,
    parameter logic [NUM_SLAVES*32-1:0]  SLAVE_BASES    = {32'h3000_0000, 32'h2000_0000,
                                                           32'h1000_0000, 32'h0000_0000},
    parameter logic [NUM_SLAVES*32-1:0]  SLAVE_MASKS    = {4{32'hF000_0000}},
    parameter int                        TIMEOUT_CYCLES = 255,
    parameter logic [31:0]               DEFAULT_READ   = 32'hDEADBEEF
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [31:0]                data_address,
    input  logic                       data_memory_read,
    input  logic                       data_memory_write,
    input  logic [31:0]                write_data,
    output logic [31:0]                read_data,
    output logic                       data_memory_response,
    output logic [31:0]                slave_address,
    output logic [31:0]                slave_write_data,
    output logic [NUM_SLAVES-1:0]      slave_read,
    output logic [NUM_SLAVES-1:0]      slave_write,
    input  logic [NUM_SLAVES*32-1:0]   slave_read_data,
    input  logic [NUM_SLAVES-1:0]      slave_response,
    output logic                       bus_error,
    output logic [15:0]                err_count,
    output logic [31:0]                err_address
);

    localparam int IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2,
        ERR    = 2'd3
    } state_t;

    state_t                  state_reg;
    logic [31:0]             addr_reg;
    logic [31:0]             wdata_reg;
    logic [31:0]             read_data_reg;
    logic                    op_read_reg;
    logic [IDX_W-1:0]        idx_reg;
    logic [15:0]             count_reg;
    logic [NUM_SLAVES-1:0]   rd_strobe_reg;
    logic [NUM_SLAVES-1:0]   wr_strobe_reg;
    logic                    response_reg;
    logic                    bus_error_reg;

    // Address decode and per-slave read-data unpacking
    logic [NUM_SLAVES-1:0]   hit;
    logic [31:0]             slot_data [NUM_SLAVES];

    generate
        for (genvar gi = 0; gi < NUM_SLAVES; gi++) begin : g_slot
            assign hit[gi]       = (data_address & SLAVE_MASKS[gi*32 +: 32]) == SLAVE_BASES[gi*32 +: 32];
            assign slot_data[gi] = slave_read_data[gi*32 +: 32];
        end
    endgenerate

    logic [IDX_W-1:0]        hit_idx;
    logic [NUM_SLAVES-1:0]   hit_onehot;
    logic                    any_hit;

    always_comb begin
        hit_idx = '0;
        // Scan downwards so the lowest matching index is the one left behind
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if (hit[i]) begin
                hit_idx = IDX_W'(i);
            end
        end
    end

    // Isolate the lowest set bit: same priority as hit_idx, in one-hot form
    assign hit_onehot = hit & ~(hit - NUM_SLAVES'(1));
    assign any_hit    = |hit;

    logic request;
    logic accept;
    logic sel_resp;
    logic timeout_hit;
    logic err_entry;

    assign request     = data_memory_read | data_memory_write;
    assign accept      = (state_reg == IDLE) && (data_memory_read ^ data_memory_write) && any_hit;
    // Only the selected slave's response matters; others are ignored
    assign sel_resp    = slave_response[idx_reg];
    assign timeout_hit = (count_reg == 16'(TIMEOUT_CYCLES - 1));
    assign err_entry   = ((state_reg == IDLE) && request && !accept) ||
                         ((state_reg == ACCESS) && !sel_resp && timeout_hit);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            addr_reg      <= '0;
            wdata_reg     <= '0;
            read_data_reg <= '0;
            op_read_reg   <= 1'b0;
            idx_reg       <= '0;
            count_reg     <= '0;
            rd_strobe_reg <= '0;
            wr_strobe_reg <= '0;
            response_reg  <= 1'b0;
            bus_error_reg <= 1'b0;
        end else begin
            // Completion and error are single-cycle pulses
            response_reg  <= 1'b0;
            bus_error_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (request) begin
                        addr_reg    <= data_address;
                        wdata_reg   <= write_data;
                        op_read_reg <= data_memory_read;
                        idx_reg     <= hit_idx;
                        count_reg   <= '0;
                    end
                    if (accept) begin
                        state_reg     <= ACCESS;
                        rd_strobe_reg <= data_memory_read  ? hit_onehot : '0;
                        wr_strobe_reg <= data_memory_write ? hit_onehot : '0;
                    end else if (err_entry) begin
                        state_reg     <= ERR;
                        response_reg  <= 1'b1;
                        bus_error_reg <= 1'b1;
                        if (data_memory_read) begin
                            read_data_reg <= DEFAULT_READ;
                        end
                    end
                end
                ACCESS: begin
                    if (sel_resp) begin
                        state_reg     <= RESP;
                        rd_strobe_reg <= '0;
                        wr_strobe_reg <= '0;
                        response_reg  <= 1'b1;
                        if (op_read_reg) begin
                            read_data_reg <= slot_data[idx_reg];
                        end
                    end else if (err_entry) begin
                        state_reg     <= ERR;
                        rd_strobe_reg <= '0;
                        wr_strobe_reg <= '0;
                        response_reg  <= 1'b1;
                        bus_error_reg <= 1'b1;
                        if (op_read_reg) begin
                            read_data_reg <= DEFAULT_READ;
                        end
                    end else begin
                        count_reg <= count_reg + 16'd1;
                    end
                end
                RESP:    state_reg <= IDLE;
                ERR:     state_reg <= IDLE;
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign read_data            = read_data_reg;
    assign data_memory_response = response_reg;
    assign bus_error            = bus_error_reg;
    assign slave_address        = addr_reg;
    assign slave_write_data     = wdata_reg;
    assign slave_read           = rd_strobe_reg;
    assign slave_write          = wr_strobe_reg;

`ifdef BUS_ERROR_STATUS_EN
    logic [15:0] err_count_reg;
    logic [31:0] err_address_reg;

    // Updated on entry to ERR so the status is visible alongside bus_error
    always_ff @(posedge clk) begin
        if (reset) begin
            err_count_reg   <= '0;
            err_address_reg <= '0;
        end else if (err_entry) begin
            if (err_count_reg != 16'hFFFF) begin
                err_count_reg <= err_count_reg + 16'd1;
            end
            // Decode errors latch the address in the same edge, so take it direct
            err_address_reg <= (state_reg == IDLE) ? data_address : addr_reg;
        end
    end

    assign err_count   = err_count_reg;
    assign err_address = err_address_reg;
`else
    assign err_count   = 16'd0;
    assign err_address = 32'd0;
`endif

endmodule

// File: tb/tb_data_bus_interconnect.sv
// ---------------------------------------------------------------------------
// Bench for data_bus_interconnect: directed transactions against a small
// transaction-level model. Every cycle the DUT outputs are compared with
// expectations computed from decode/latency rules; a few hand-computed
// literals pin the model itself.
// ---------------------------------------------------------------------------
module tb_data_bus_interconnect;

    localparam int NS   = 4;
    localparam int TMO  = 8;
    localparam int MAXC = 1024;
    localparam logic [31:0] DEF_RD = 32'hDEADBEEF;
    localparam logic [NS*32-1:0] BASES = {32'h1000_0000, 32'h2000_0000, 32'h1000_0000, 32'h0000_0000};
    localparam logic [NS*32-1:0] MASKS = {32'hF000_0000, 32'hFFFF_0000, 32'hF000_0000, 32'hF000_0000};

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [31:0]       data_address = '0;
    logic              data_memory_read = 1'b0;
    logic              data_memory_write = 1'b0;
    logic [31:0]       write_data = '0;
    logic [31:0]       read_data;
    logic              data_memory_response;
    logic [31:0]       slave_address;
    logic [31:0]       slave_write_data;
    logic [NS-1:0]     slave_read;
    logic [NS-1:0]     slave_write;
    logic [NS*32-1:0]  slave_read_data;
    logic [NS-1:0]     slave_response;
    logic              bus_error;
    logic [15:0]       err_count;
    logic [31:0]       err_address;

    always #5 clk = ~clk;

    data_bus_interconnect #(
        .NUM_SLAVES     (NS),
        .SLAVE_BASES    (BASES),
        .SLAVE_MASKS    (MASKS),
        .TIMEOUT_CYCLES (TMO),
        .DEFAULT_READ   (DEF_RD)
    ) dut (
        .clk                  (clk),
        .reset                (reset),
        .data_address         (data_address),
        .data_memory_read     (data_memory_read),
        .data_memory_write    (data_memory_write),
        .write_data           (write_data),
        .read_data            (read_data),
        .data_memory_response (data_memory_response),
        .slave_address        (slave_address),
        .slave_write_data     (slave_write_data),
        .slave_read           (slave_read),
        .slave_write          (slave_write),
        .slave_read_data      (slave_read_data),
        .slave_response       (slave_response),
        .bus_error            (bus_error),
        .err_count            (err_count),
        .err_address          (err_address)
    );

    // ---------------- behavioural slaves ----------------
    // wait_cfg[i] = wait cycles before responding (-1: never); tie = always responding
    int            wait_cfg [NS];
    logic [31:0]   slot     [NS];
    logic [NS-1:0] tie = 4'b1001;
    int            scnt     [NS];

    always @(posedge clk) begin
        for (int i = 0; i < NS; i++) begin
            scnt[i] <= (slave_read[i] | slave_write[i]) ? scnt[i] + 1 : 0;
        end
    end

    always_comb begin
        slave_response  = '0;
        slave_read_data = '0;
        for (int i = 0; i < NS; i++) begin
            slave_response[i] = tie[i] | ((slave_read[i] | slave_write[i]) &&
                                          wait_cfg[i] >= 0 && scnt[i] == wait_cfg[i]);
            slave_read_data[i*32 +: 32] = slot[i];
        end
    end

    // ---------------- bookkeeping ----------------
    int tests_run    = 0;
    int tests_failed = 0;
    int cyc          = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, act, exp);
        end
    endtask

    // ---------------- expectation model ----------------
    bit [NS-1:0] e_rd    [MAXC];
    bit [NS-1:0] e_wr    [MAXC];
    bit          e_resp  [MAXC];
    bit          e_berr  [MAXC];
    bit          e_rdupd [MAXC];
    bit [31:0]   e_rdval [MAXC];
    bit          e_err   [MAXC];
    bit [31:0]   e_eaddr [MAXC];
    bit          e_rst   [MAXC];
    bit [31:0]   e_saddr [MAXC];
    bit [31:0]   e_swd   [MAXC];

    logic [31:0] m_base [NS];
    logic [31:0] m_mask [NS];

    function automatic int decode(input logic [31:0] a);
        for (int i = 0; i < NS; i++) begin
            if ((a & m_mask[i]) == m_base[i]) return i;
        end
        return -1;
    endfunction

    // Drives one transaction starting in the current cycle. abort_at>0 asserts
    // reset that many cycles into the access. Returns the start cycle.
    task automatic run_txn(input bit rd, input bit wr, input logic [31:0] addr,
                           input logic [31:0] wd, input int abort_at, output int start);
        int c;
        int idx;
        int w;
        int n;
        int resp_c;
        bit ok;
        c = cyc;
        start = c;
        idx = decode(addr);
        if (idx < 0 || (rd && wr)) begin
            resp_c = c + 1;
            ok = 1'b0;
        end else begin
            w  = tie[idx] ? 0 : wait_cfg[idx];
            ok = (w >= 0) && (w < TMO);
            n  = ok ? w + 1 : TMO;
            if (abort_at > 0) n = abort_at;
            for (int k = 1; k <= n; k++) begin
                if (rd) e_rd[c+k][idx] = 1'b1;
                else    e_wr[c+k][idx] = 1'b1;
                e_saddr[c+k] = addr;
                e_swd[c+k]   = wd;
            end
            resp_c = c + n + 1;
        end
        if (abort_at > 0) begin
            e_rst[c + abort_at + 1] = 1'b1;
        end else begin
            e_resp[resp_c] = 1'b1;
            if (ok) begin
                if (rd) begin
                    e_rdupd[resp_c] = 1'b1;
                    e_rdval[resp_c] = slot[idx];
                end
            end else begin
                e_berr[resp_c]  = 1'b1;
                e_err[resp_c]   = 1'b1;
                e_eaddr[resp_c] = addr;
                if (rd) begin
                    e_rdupd[resp_c] = 1'b1;
                    e_rdval[resp_c] = DEF_RD;
                end
            end
        end

        data_address      = addr;
        write_data        = wd;
        data_memory_read  = rd;
        data_memory_write = wr;

        if (abort_at > 0) begin
            while (cyc < c + abort_at) begin @(posedge clk); #1; end
            reset = 1'b1;
            @(posedge clk); #1;
            reset = 1'b0;
        end else begin
            while (cyc < resp_c) begin @(posedge clk); #1; end
            @(posedge clk); #1;
        end
        data_memory_read  = 1'b0;
        data_memory_write = 1'b0;
    endtask

    // ---------------- per-cycle compare ----------------
    logic [31:0] exp_rd  = '0;
    logic [15:0] exp_cnt = '0;
    logic [31:0] exp_ea  = '0;
    int obs_resp_cyc   = 0;
    int obs_berr_total = 0;
    int obs_strb_total = 0;

    always @(negedge clk) begin
        if (cyc >= 1 && cyc < MAXC) begin
            if (e_rst[cyc]) begin
                exp_rd  = '0;
                exp_cnt = '0;
                exp_ea  = '0;
            end
            if (e_rdupd[cyc]) exp_rd = e_rdval[cyc];
            if (e_err[cyc]) begin
                if (exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
                exp_ea = e_eaddr[cyc];
            end
            chk("slave_read",  32'(slave_read),  32'(e_rd[cyc]));
            chk("slave_write", 32'(slave_write), 32'(e_wr[cyc]));
            chk("response",    32'(data_memory_response), 32'(e_resp[cyc]));
            chk("bus_error",   32'(bus_error), 32'(e_berr[cyc]));
            chk("read_data",   read_data, exp_rd);
            if ((e_rd[cyc] | e_wr[cyc]) != '0) begin
                chk("slave_address", slave_address, e_saddr[cyc]);
                if (e_wr[cyc] != '0) chk("slave_write_data", slave_write_data, e_swd[cyc]);
            end
`ifdef BUS_ERROR_STATUS_EN
            chk("err_count",   32'(err_count), 32'(exp_cnt));
            chk("err_address", err_address, exp_ea);
`else
            chk("err_count",   32'(err_count), 32'd0);
            chk("err_address", err_address, 32'd0);
`endif
            if (data_memory_response) obs_resp_cyc = cyc;
            if (bus_error) obs_berr_total++;
            obs_strb_total += $countones(slave_read | slave_write);
        end
    end

    // ---------------- directed sequence ----------------
    int st;
    int s0;
    int b0;
    int r0;

    task automatic report(input string name, input int st_c, input int lat, input int strb, input int berr);
        chk({name, "_latency"}, 32'(obs_resp_cyc - st_c), 32'(lat));
        chk({name, "_strobes"}, 32'(obs_strb_total - s0), 32'(strb));
        chk({name, "_berr"},    32'(obs_berr_total - b0), 32'(berr));
        $display("[TB] %s: start=%0d resp=%0d read_data=%h bus_error_pulses=%0d",
                 name, st_c, obs_resp_cyc, read_data, obs_berr_total - b0);
    endtask

    initial begin
        for (int i = 0; i < NS; i++) begin
            m_base[i] = BASES[i*32 +: 32];
            m_mask[i] = MASKS[i*32 +: 32];
        end
        slot[0] = 32'h1234_5678;
        slot[1] = 32'hCAFE_0001;
        slot[2] = 32'h0BAD_F00D;
        slot[3] = 32'hFFFF_FFFF;
        wait_cfg[0] = 0;
        wait_cfg[1] = 3;
        wait_cfg[2] = -1;
        wait_cfg[3] = 0;

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        chk("reset_read_data", read_data, 32'd0);
        chk("reset_response",  32'(data_memory_response), 32'd0);
        chk("reset_strobes",   32'(slave_read | slave_write), 32'd0);
        @(posedge clk); #1;

        // Read slave0 with response tied high
        s0 = obs_strb_total; b0 = obs_berr_total;
        run_txn(1, 0, 32'h0000_0000, 32'd0, 0, st);
        report("read_s0", st, 2, 1, 0);
        chk("read_s0_data", read_data, 32'h1234_5678);

        // Write to slave1 (overlaps slave3, lower index wins), 3 wait cycles
        s0 = obs_strb_total; b0 = obs_berr_total;
        run_txn(0, 1, 32'h1000_0010, 32'h0000_00A5, 0, st);
        report("write_s1", st, 5, 4, 0);
        chk("write_keeps_read_data", read_data, 32'h1234_5678);

        // Unmapped read
        s0 = obs_strb_total; b0 = obs_berr_total;
        run_txn(1, 0, 32'hF000_0000, 32'd0, 0, st);
        report("unmapped", st, 1, 0, 1);
        chk("unmapped_data", read_data, 32'hDEAD_BEEF);

        // Slave2 never responds -> timeout after 8 strobe cycles
        s0 = obs_strb_total; b0 = obs_berr_total;
        run_txn(1, 0, 32'h2000_0040, 32'd0, 0, st);
        report("timeout", st, 9, 8, 1);
`ifdef BUS_ERROR_STATUS_EN
        chk("timeout_err_count", 32'(err_count), 32'd2);
`else
        chk("timeout_err_count", 32'(err_count), 32'd0);
`endif

        // Read and write together
        s0 = obs_strb_total; b0 = obs_berr_total;
        run_txn(1, 1, 32'h1000_0000, 32'h5555_5555, 0, st);
        report("rd_and_wr", st, 1, 0, 1);

        // Slave1 read with slave3 tied high: unselected response ignored
        wait_cfg[1] = 2;
        s0 = obs_strb_total; b0 = obs_berr_total;
        run_txn(1, 0, 32'h1000_0004, 32'd0, 0, st);
        report("read_s1", st, 4, 3, 0);
        chk("read_s1_data", read_data, 32'hCAFE_0001);

        // Timeout boundary: response in the last allowed cycle, then one too late
        wait_cfg[2] = TMO - 1;
        s0 = obs_strb_total; b0 = obs_berr_total;
        run_txn(1, 0, 32'h2000_0004, 32'd0, 0, st);
        report("last_cycle_ok", st, 9, 8, 0);
        chk("last_cycle_data", read_data, 32'h0BAD_F00D);
        wait_cfg[2] = TMO;
        s0 = obs_strb_total; b0 = obs_berr_total;
        run_txn(0, 1, 32'h2000_0008, 32'h0000_1111, 0, st);
        report("one_too_late", st, 9, 8, 1);

        // Outside slave2's narrow mask
        s0 = obs_strb_total; b0 = obs_berr_total;
        run_txn(1, 0, 32'h2001_0000, 32'd0, 0, st);
        report("narrow_mask", st, 1, 0, 1);

        // Reset in the middle of an access, then a normal access
        wait_cfg[1] = 5;
        r0 = obs_resp_cyc;
        run_txn(1, 0, 32'h1000_0000, 32'd0, 2, st);
        chk("abort_no_response", 32'(obs_resp_cyc), 32'(r0));
        chk("abort_read_data", read_data, 32'd0);
        chk("abort_strobes", 32'(slave_read | slave_write), 32'd0);
        wait_cfg[1] = 0;
        s0 = obs_strb_total; b0 = obs_berr_total;
        run_txn(0, 1, 32'h1000_0020, 32'h0000_0077, 0, st);
        report("after_reset", st, 2, 1, 0);

        repeat (3) @(posedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
